shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port clear, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port input_start, input, 1 bit: request to begin a multiply, sampled on the rising edge.
REQ-005 The block SHALL have port is_signed, input, 1 bit: 1 selects two's-complement operands, 0 selects unsigned; sampled with input_start.
REQ-006 The block SHALL have port A, input, WIDTH bits: multiplicand, sampled with input_start.
REQ-007 The block SHALL have port B, input, WIDTH bits: multiplier, sampled with input_start.
REQ-008 The block SHALL have port out, output reg, 2*WIDTH bits: product of the last completed operation.
REQ-009 The block SHALL have port busy, output reg, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done, output reg, 1 bit: high once a result is valid on out; stays high until the next accepted start.

Function
REQ-011 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-012 The block SHALL accept input_start=1 only in IDLE or DONE.
- On acceptance it SHALL latch |A|, |B| (or raw A, B when unsigned) and the result sign (A[msb] XOR B[msb], when signed).
- It SHALL also clear the accumulator, load the bit counter with WIDTH, set busy=1, set done=0, and enter RUN.
REQ-013 The block SHALL ignore input_start while in RUN; operands, mode and progress SHALL be unaffected.
REQ-014 Each RUN cycle SHALL perform one radix-2 shift-add step:
- If the multiplier LSB is 1, add the multiplicand (aligned to the current bit position) into the 2*WIDTH-bit accumulator.
- Shift the multiplier right by one.
- Decrement the counter.
REQ-015 All intermediate arithmetic SHALL be at least 2*WIDTH bits wide, with no truncation.
REQ-016 If start is accepted at edge k, the final RUN step SHALL occur at edge k+WIDTH. At that edge the block SHALL:
- load out with the exact product (two's-complement negated when signed and the latched sign is 1);
- set done=1 and busy=0;
- enter DONE.
The latency is therefore fixed at WIDTH cycles, independent of operand values.
REQ-017 out SHALL change only at completion (REQ-016) or reset; it SHALL hold the previous result throughout RUN.
REQ-018 Signed mode SHALL produce the exact result for the most-negative operands, e.g. WIDTH=8: -128*-128 = 0x4000.
REQ-019 An operand of 0 SHALL still take the full WIDTH cycles and produce out=0.
REQ-020 A start in DONE SHALL be accepted on that edge (back-to-back operation); done SHALL fall on the same edge.
REQ-021 A start in IDLE or DONE SHALL take effect even when it coincides with any other condition, except clear.

Reset
REQ-022 While clear=1, the block SHALL force, regardless of clk:
- state=IDLE, out=0, busy=0, done=0;
- accumulator, operand registers and counter to 0.
REQ-023 clear asserted mid-RUN SHALL abandon the operation; no partial result SHALL ever reach out.
REQ-024 input_start held high while clear=1 SHALL be ignored. The first start SHALL be accepted on the first rising edge after clear deasserts.

Verification
REQ-025 WIDTH=8, unsigned: A=13, B=11, one-cycle start -> busy high for 8 cycles; then out=143 (0x008F), done=1, busy=0.
REQ-026 WIDTH=8, unsigned: A=255, B=255 -> out=0xFE01. Signed: A=-3 (0xFD), B=5 -> out=0xFFF1. Signed: A=0x80, B=0x80 -> out=0x4000.
REQ-027 Start A=7, B=9, then pulse start with A=2, B=2 at cycle 3 of RUN -> second start ignored; out=63 after 8 cycles.
REQ-028 Start A=100, B=3; assert clear at cycle 4 -> out=0, done=0, busy=0 immediately. After clear release, start A=6, B=7 -> out=42.
REQ-029 Result 143 in DONE; start A=0, B=200 on the next edge -> done falls on that edge and out holds 143 during RUN. After 8 cycles out=0 and done=1.
REQ-030 Repeat REQ-025 and REQ-026 with WIDTH=4 (signed -8*-8 -> 0x40) and WIDTH=16 (unsigned 65535*65535 -> 0xFFFE0001), checking 4- and 16-cycle latency.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Radix-2 sequential shift-add multiplier, signed/unsigned.
// Fixed WIDTH-cycle latency; the result is registered on completion.
module shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               clear,
   input  logic               input_start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] out,
   output logic               busy,
   output logic               done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             state;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] sum;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [CW-1:0]      cnt;
   logic               neg;

   // Magnitude of the most-negative value still fits as an unsigned WIDTH-bit number.
   always_comb begin
      a_mag = A;
      b_mag = B;
      if (is_signed && A[WIDTH-1]) a_mag = -A;
      if (is_signed && B[WIDTH-1]) b_mag = -B;
      sum = acc + (mplier[0] ? mcand : '0);
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state  <= IDLE;
         out    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               acc    <= sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  out   <= neg ? -sum : sum;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               if (input_start) begin
                  mcand  <= {{WIDTH{1'b0}}, a_mag};
                  mplier <= b_mag;
                  neg    <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                  acc    <= '0;
                  cnt    <= CNT_INIT;
                  busy   <= 1'b1;
                  done   <= 1'b0;
                  state  <= RUN;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier at WIDTH 4, 8 and 16.
// Expected products are hand-computed constants.
module tb_shift_add_multiplier;

   logic clk = 1'b0;
   logic clear = 1'b1;

   logic st4 = 1'b0, sg4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic [7:0] o4;
   logic bz4, dn4;

   logic st8 = 1'b0, sg8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic [15:0] o8;
   logic bz8, dn8;

   logic st16 = 1'b0, sg16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic [31:0] o16;
   logic bz16, dn16;

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   shift_add_multiplier #(.WIDTH(4)) u4 (
      .clk(clk), .clear(clear), .input_start(st4), .is_signed(sg4),
      .A(a4), .B(b4), .out(o4), .busy(bz4), .done(dn4));

   shift_add_multiplier #(.WIDTH(8)) u8 (
      .clk(clk), .clear(clear), .input_start(st8), .is_signed(sg8),
      .A(a8), .B(b8), .out(o8), .busy(bz8), .done(dn8));

   shift_add_multiplier #(.WIDTH(16)) u16 (
      .clk(clk), .clear(clear), .input_start(st16), .is_signed(sg16),
      .A(a16), .B(b16), .out(o16), .busy(bz16), .done(dn16));

   function automatic logic dn(int w);
      case (w)
         4:       return dn4;
         16:      return dn16;
         default: return dn8;
      endcase
   endfunction

   function automatic logic bs(int w);
      case (w)
         4:       return bz4;
         16:      return bz16;
         default: return bz8;
      endcase
   endfunction

   function automatic logic [31:0] ot(int w);
      case (w)
         4:       return {24'd0, o4};
         16:      return o16;
         default: return {16'd0, o8};
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic go(int w, logic s, logic [15:0] a, logic [15:0] b);
      case (w)
         4:       begin sg4 = s; a4 = a[3:0]; b4 = b[3:0]; st4 = 1'b1; end
         16:      begin sg16 = s; a16 = a; b16 = b; st16 = 1'b1; end
         default: begin sg8 = s; a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1; end
      endcase
   endtask

   task automatic stop(int w);
      case (w)
         4:       st4 = 1'b0;
         16:      st16 = 1'b0;
         default: st8 = 1'b0;
      endcase
   endtask

   // Called after n0 rising edges past the accepting edge.
   task automatic wait_done(int w, logic [31:0] exp, int n0);
      int n;
      n = n0;
      chk("busy_run", {31'd0, bs(w)}, 32'd1);
      chk("done_run", {31'd0, dn(w)}, 32'd0);
      while (!dn(w) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("latency", n, w);
      chk("product", ot(w), exp);
      chk("busy_end", {31'd0, bs(w)}, 32'd0);
   endtask

   task automatic mul(int w, logic s, logic [15:0] a, logic [15:0] b,
                      logic [31:0] exp);
      @(negedge clk);
      go(w, s, a, b);
      @(negedge clk);
      stop(w);
      wait_done(w, exp, 0);
   endtask

   initial begin
      // Start held during clear must be ignored
      go(8, 1'b0, 16'd13, 16'd11);
      @(negedge clk);
      @(negedge clk);
      chk("rst_out8", ot(8), 32'd0);
      chk("rst_busy8", {31'd0, bz8}, 32'd0);
      chk("rst_done8", {31'd0, dn8}, 32'd0);
      chk("rst_out4", ot(4), 32'd0);
      chk("rst_out16", ot(16), 32'd0);
      clear = 1'b0;
      @(negedge clk);
      stop(8);
      wait_done(8, 32'h8F, 0);

      mul(8, 1'b0, 16'd255, 16'd255, 32'hFE01);
      mul(8, 1'b1, 16'hFD, 16'd5, 32'hFFF1);
      mul(8, 1'b1, 16'h80, 16'h80, 32'h4000);
      mul(8, 1'b1, 16'h7F, 16'h80, 32'hC080);
      mul(8, 1'b0, 16'h80, 16'h80, 32'h4000);

      // Start pulsed in RUN is ignored
      @(negedge clk);
      go(8, 1'b0, 16'd7, 16'd9);
      @(negedge clk);
      stop(8);
      @(negedge clk);
      @(negedge clk);
      go(8, 1'b0, 16'd2, 16'd2);
      @(negedge clk);
      stop(8);
      wait_done(8, 32'd63, 3);

      // Clear mid-run abandons the operation
      @(negedge clk);
      go(8, 1'b0, 16'd100, 16'd3);
      @(negedge clk);
      stop(8);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      clear = 1'b1;
      #1;
      chk("clr_out", ot(8), 32'd0);
      chk("clr_done", {31'd0, dn8}, 32'd0);
      chk("clr_busy", {31'd0, bz8}, 32'd0);
      @(negedge clk);
      clear = 1'b0;
      mul(8, 1'b0, 16'd6, 16'd7, 32'd42);

      // Back-to-back start from DONE
      mul(8, 1'b0, 16'd13, 16'd11, 32'h8F);
      go(8, 1'b0, 16'd0, 16'd200);
      @(negedge clk);
      stop(8);
      chk("b2b_done_fall", {31'd0, dn8}, 32'd0);
      chk("b2b_out_hold", ot(8), 32'h8F);
      @(negedge clk);
      @(negedge clk);
      chk("b2b_out_mid", ot(8), 32'h8F);
      wait_done(8, 32'd0, 2);
      chk("b2b_done_hold", {31'd0, dn8}, 32'd1);

      mul(4, 1'b0, 16'd13, 16'd11, 32'h8F);
      mul(4, 1'b0, 16'd15, 16'd15, 32'hE1);
      mul(4, 1'b1, 16'hD, 16'd5, 32'hF1);
      mul(4, 1'b1, 16'h8, 16'h8, 32'h40);

      mul(16, 1'b0, 16'd13, 16'd11, 32'h8F);
      mul(16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
      mul(16, 1'b1, 16'hFFFD, 16'd5, 32'hFFFFFFF1);
      mul(16, 1'b1, 16'h8000, 16'h8000, 32'h40000000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
